nibble_serial_subtractor: RTL
=============================

# nibble_serial_subtractor

Multi-nibble sequential subtractor that computes Diff = A − B − Borrow over a 4·NIBBLES-bit operand, one nibble per clock, by time-multiplexing a single instance of the team's Subtractor_4 slice. It sits directly upstream of that slice: it latches full-width operands, feeds it one nibble pair per cycle with the borrow chained through a register, and collects its difference and borrow outputs. Results are presented under a start/done handshake to the calculator datapath.

## Interface
- NIBBLES, default 4: number of 4-bit slices; operand width W = 4·NIBBLES; must be ≥ 2.
- Clk_in  input  1  system clock; all state updates on the rising edge.
- Reset_in  input  1  reset, asynchronous and active-high.
- Start_in  input  1  request; accepted only while Ready_out = 1.
- A_in  input  W  minuend; sampled on the accept edge.
- B_in  input  W  subtrahend; sampled on the accept edge.
- Borrow_in  input  1  initial borrow into nibble 0; sampled on the accept edge.
- Ready_out  output  1  high in IDLE and DONE.
- Busy_out  output  1  high in RUN.
- Done_out  output  1  one-cycle pulse; result registers valid from this cycle.
- Diff_out  output  W  result, held until the next completion.
- Borrow_out  output  1  final borrow from the top nibble (unsigned A < B + Borrow_in).
- Zero_out  output  1  Diff_out == 0.
- Overflow_out  output  1  signed overflow: A[W−1] ≠ B[W−1] and Diff_out[W−1] ≠ A[W−1].

## Operation
- States: IDLE, RUN, DONE.
- IDLE → RUN on Start_in.
  - Latch A_reg, B_reg and borrow_reg ← Borrow_in.
  - Clear index and the work register.
- RUN, one cycle per nibble:
  - The slice receives A_reg[4i+3:4i], B_reg[4i+3:4i] and borrow_reg, where i = index.
  - On the edge: work[4i+3:4i] ← slice difference; borrow_reg ← slice Carry_out (borrow); index increments.
  - After the cycle with index = NIBBLES−1, go to DONE.
- Entering DONE, on that same edge:
  - Diff_out ← completed work register (including the top nibble).
  - Borrow_out ← final borrow.
  - Zero_out and Overflow_out are computed from the final values and registered.
- DONE:
  - Done_out = 1 for exactly one cycle; state then returns to IDLE.
  - If Start_in = 1 in DONE, it is accepted (DONE → RUN directly, back-to-back); Done_out still pulses this cycle.
- Start_in while Busy_out = 1 is ignored: no latch, no effect on the running operation.
- Result outputs (Diff_out, Borrow_out, Zero_out, Overflow_out) change only on the edge entering DONE. They never show partial results during RUN.
- Arithmetic is modulo 2^W, with borrow semantics matching the slice: difference = A − B − borrow_in_nibble; Carry_out = 1 when borrow occurs.
- A_in, B_in and Borrow_in may change freely after the accept edge.

## Timing
- Reset (asynchronous assert): state IDLE, index 0, A_reg, B_reg and borrow_reg all 0.
  - Diff_out 0, Borrow_out 0, Zero_out 0, Overflow_out 0, Done_out 0, Busy_out 0, Ready_out 1.
- Release is used synchronously: the first accept is possible on the first rising edge with Reset_in low.
- Latency: Start_in sampled at edge 0 → Busy_out high for cycles 1..NIBBLES → Done_out high in cycle NIBBLES+1.
- Throughput: one result per NIBBLES+1 cycles with back-to-back starts.
- Reset during RUN or DONE:
  - The operation is aborted and no Done_out is produced.
  - All outputs return to reset values immediately (asynchronously).
- Ready_out, Busy_out and Done_out are registered-state decodes, glitch-free relative to Clk_in.

## Test plan
- NIBBLES=4: A=0x1234, B=0x0234, Borrow_in=0, Start at edge 0 → Busy cycles 1–4; Done_out in cycle 5; Diff_out=0x1000, Borrow_out=0, Zero_out=0, Overflow_out=0.
- A=0x0000, B=0x0001, Borrow_in=0 → Diff_out=0xFFFF, Borrow_out=1, Overflow_out=0. Then A=0x5A5A, B=0x5A5A → Diff_out=0x0000, Zero_out=1, Borrow_out=0.
- A=0x8000, B=0x0000, Borrow_in=1 → Diff_out=0x7FFF, Borrow_out=0, Overflow_out=1. Then A=0x7FFF, B=0xFFFF, Borrow_in=0 → Diff_out=0x8000, Borrow_out=1, Overflow_out=1.
- Start A=0x00F0, B=0x000F; in cycle 2 pulse Start_in with A=0xFFFF, B=0xFFFF → ignored; Done in cycle 5 with Diff_out=0x00E1. Reassert Start_in in the DONE cycle with A=0x0010, B=0x0001 → Done_out again 5 cycles later, Diff_out=0x000F.
- Start A=0x1111, B=0x0001; assert Reset_in mid-cycle during cycle 3 → Busy_out, Done_out and Diff_out drop to 0 without waiting for an edge, Ready_out=1, no Done pulse. Next start with A=0x0003, B=0x0005 → Diff_out=0xFFFE, Borrow_out=1.
- Random: 1000 operand/Borrow_in triples, with NIBBLES = 2 and 4. Compare Diff_out and Borrow_out against (A − B − Borrow_in) mod 2^W and its unsigned underflow. Check Done_out spacing equals NIBBLES+1 under continuous Start_in.

Source files
------------

// File: rtl/nibble_serial_subtractor.sv
// nibble_serial_subtractor: W-bit (W = 4*NIBBLES) subtractor computing
// Diff = A - B - Borrow by running one 4-bit subtractor slice over the
// operand, least-significant nibble first, with the borrow kept in a register.
//
// Ports:
//   Clk_in        rising-edge clock
//   Reset_in      asynchronous, active-high reset
//   Start_in      request, accepted while Ready_out = 1
//   A_in, B_in    minuend / subtrahend, sampled on the accept edge
//   Borrow_in     borrow into nibble 0, sampled on the accept edge
//   Ready_out     idle or finishing, a new request is accepted
//   Busy_out      nibble loop in progress
//   Done_out      one-cycle pulse, result outputs valid from this cycle
//   Diff_out      W-bit difference, held until the next completion
//   Borrow_out    borrow out of the top nibble (unsigned A < B + Borrow_in)
//   Zero_out      Diff_out == 0
//   Overflow_out  signed overflow of the subtraction

// subtractor_4: 4-bit subtractor slice, Diff = A - B - Borrow_in, Carry_out = borrow.
// Latency: purely combinational.
// Backpressure: none, it evaluates whatever is presented.
module subtractor_4 (
  input  logic [3:0] A_in,
  input  logic [3:0] B_in,
  input  logic       Borrow_in,
  output logic [3:0] Diff_out,
  output logic       Carry_out
);

  // A 5-bit subtraction: bit 4 goes high exactly when the nibble underflows.
  logic [4:0] full_diff;

  assign full_diff = {1'b0, A_in} - {1'b0, B_in} - {4'b0000, Borrow_in};
  assign Diff_out  = full_diff[3:0];
  assign Carry_out = full_diff[4];

endmodule

// nibble_serial_subtractor: sequential A - B - Borrow over NIBBLES nibbles.
// Latency: accept edge -> Busy for NIBBLES cycles -> Done pulse in cycle NIBBLES+1.
// Backpressure: Start_in is ignored while Busy_out = 1; a start during DONE runs back-to-back.
module nibble_serial_subtractor #(
  parameter int NIBBLES = 4
) (
  input  logic                   Clk_in,
  input  logic                   Reset_in,
  input  logic                   Start_in,
  input  logic [4*NIBBLES-1:0]   A_in,
  input  logic [4*NIBBLES-1:0]   B_in,
  input  logic                   Borrow_in,
  output logic                   Ready_out,
  output logic                   Busy_out,
  output logic                   Done_out,
  output logic [4*NIBBLES-1:0]   Diff_out,
  output logic                   Borrow_out,
  output logic                   Zero_out,
  output logic                   Overflow_out
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  // Encoding chosen so each handshake output is a single flop bit:
  // Busy = bit 0, Done = bit 1, Ready = ~bit 0. No decode glitches.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t          state_q;
  state_t          state_d;

  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;
  logic            borrow_reg;
  logic [IW-1:0]   idx_q;
  logic [W-1:0]    work_q;
  logic [W-1:0]    work_d;

  logic [3:0]      a_nib;
  logic [3:0]      b_nib;
  logic [3:0]      slice_diff;
  logic            slice_borrow;

  logic            accept;
  logic            last_nib;

  // A request is taken whenever the FSM is not mid-operation.
  assign accept   = Start_in && (state_q != ST_RUN);
  assign last_nib = (idx_q == IW'(NIBBLES - 1));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk_in or posedge Reset_in) begin
    if (Reset_in) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (Start_in) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (last_nib) state_d = ST_DONE;
      end
      ST_DONE: begin
        // A start in the completion cycle chains straight into the next run.
        state_d = Start_in ? ST_RUN : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs, taken directly from state flop bits
  // ---------------------------------------------------------------------------
  always_comb begin
    Busy_out  = state_q[0];
    Done_out  = state_q[1];
    Ready_out = ~state_q[0];
  end

  // ---------------------------------------------------------------------------
  // Nibble select: route nibble idx_q of the latched operands into the slice.
  // ---------------------------------------------------------------------------
  always_comb begin
    a_nib = 4'h0;
    b_nib = 4'h0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_q == IW'(i)) begin
        a_nib = a_reg[4*i +: 4];
        b_nib = b_reg[4*i +: 4];
      end
    end
  end

  subtractor_4 u_slice (
    .A_in      (a_nib),
    .B_in      (b_nib),
    .Borrow_in (borrow_reg),
    .Diff_out  (slice_diff),
    .Carry_out (slice_borrow)
  );

  // Work register with the current slice result merged in. On the last nibble
  // this is the complete difference, which is what gets published.
  always_comb begin
    work_d = work_q;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_q == IW'(i)) begin
        work_d[4*i +: 4] = slice_diff;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Operand latch, borrow chain, nibble index and work register
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk_in or posedge Reset_in) begin
    if (Reset_in) begin
      a_reg      <= '0;
      b_reg      <= '0;
      borrow_reg <= 1'b0;
      idx_q      <= '0;
      work_q     <= '0;
    end else if (accept) begin
      a_reg      <= A_in;
      b_reg      <= B_in;
      borrow_reg <= Borrow_in;
      idx_q      <= '0;
      work_q     <= '0;
    end else if (state_q == ST_RUN) begin
      work_q     <= work_d;
      borrow_reg <= slice_borrow;
      // Explicit wrap keeps the index sane for non-power-of-two NIBBLES.
      idx_q      <= last_nib ? '0 : idx_q + IW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Result registers: updated only on the edge that enters DONE, so partial
  // results never appear on the outputs while the loop is running.
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk_in or posedge Reset_in) begin
    if (Reset_in) begin
      Diff_out     <= '0;
      Borrow_out   <= 1'b0;
      Zero_out     <= 1'b0;
      Overflow_out <= 1'b0;
    end else if ((state_q == ST_RUN) && last_nib) begin
      Diff_out     <= work_d;
      Borrow_out   <= slice_borrow;
      Zero_out     <= (work_d == '0);
      // Signed overflow: operands of opposite sign and the result sign
      // differs from the minuend sign.
      Overflow_out <= (a_reg[W-1] ^ b_reg[W-1]) & (work_d[W-1] ^ a_reg[W-1]);
    end
  end

endmodule
